// File: rtl/video_stream_pkg.sv
// Shared Avalon-ST video definitions: pixel layout, default frame geometry and
// the capture FSM state type. Also used by the video source blocks.
package video_stream_pkg;

    localparam int PixelWidth      = 30;
    localparam int RedMsb          = 29;
    localparam int GreenMsb        = 19;
    localparam int BlueMsb         = 9;

    localparam int DefNumPixels    = 12 * 12;
    localparam int DefColourBits   = 12;
    localparam int DefAddrWidth    = 19;
    localparam int FrameCountWidth = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOP,
        CAPTURE
    } capture_state_t;

endpackage

// File: rtl/video_frame_capture_if.sv
// Avalon-ST video pixel stream: SOP/EOP framed data with valid/ready handshake.
interface video_frame_capture_if
    import video_stream_pkg::*;
#(
    parameter int Width = PixelWidth
) ();

    logic [Width-1:0] data;
    logic             startofpacket;
    logic             endofpacket;
    logic             valid;
    logic             ready;

    modport master (
        output data, startofpacket, endofpacket, valid,
        input  ready
    );

    modport slave (
        input  data, startofpacket, endofpacket, valid,
        output ready
    );

endinterface

// File: rtl/frame_buffer_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Read-during-write to the same address returns the old contents.
module frame_buffer_ram #(
    parameter int Depth     = 144,
    parameter int Width     = 12,
    parameter int AddrWidth = 19
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AddrWidth-1:0] waddr,
    input  logic [Width-1:0]     wdata,
    input  logic [AddrWidth-1:0] raddr,
    output logic [Width-1:0]     rdata
);

    localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];

    // No reset on the array or read register so the tools map this onto block RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr[IdxW-1:0]] <= wdata;
        rdata <= mem[raddr[IdxW-1:0]];
    end

    generate
        if (AddrWidth > IdxW) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^{waddr[AddrWidth-1:IdxW], raddr[AddrWidth-1:IdxW]};
        end
    endgenerate

endmodule

// File: rtl/video_frame_capture.sv
// Avalon-ST video sink: quantises pixels and captures one SOP/EOP framed frame
// into the frame buffer, flagging framing errors against NumPixels.
module video_frame_capture
    import video_stream_pkg::*;
#(
    parameter int NumPixels     = DefNumPixels,
    parameter int NumColourBits = DefColourBits,
    parameter int AddrWidth     = DefAddrWidth
) (
    input  logic                     clk,
    input  logic                     reset,
    video_frame_capture_if.slave     snk,
    input  logic                     capture_en,
    input  logic                     err_clear,
    input  logic [AddrWidth-1:0]     rd_addr,
    output logic [NumColourBits-1:0] rd_data,
    output logic                     frame_done,
    output logic [15:0]              frame_count,
    output logic                     sop_err,
    output logic                     len_err
);

    localparam int                   C          = NumColourBits / 3;
    localparam logic [AddrWidth-1:0] LastIdx    = AddrWidth'(NumPixels - 1);
    localparam bit                   SingleBeat = (NumPixels == 1);

    capture_state_t           state, state_nxt;
    logic [AddrWidth-1:0]     idx, idx_nxt, wr_addr;
    logic                     hs, last, wr_en, set_sop, set_len, done;
    logic [NumColourBits-1:0] wr_data;
    logic                     unused_data;

    assign hs          = snk.valid & snk.ready;
    assign last        = (idx == LastIdx);
    assign wr_data     = {snk.data[RedMsb -: C], snk.data[GreenMsb -: C], snk.data[BlueMsb -: C]};
    assign unused_data = ^snk.data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (capture_en) state_nxt = WAIT_SOP;
            WAIT_SOP: begin
                if (!capture_en)
                    state_nxt = IDLE;
                else if (hs && snk.startofpacket && !(SingleBeat && snk.endofpacket))
                    state_nxt = CAPTURE;
            end
            CAPTURE:  if (hs && !snk.startofpacket && (last || snk.endofpacket))
                          state_nxt = WAIT_SOP;
            default:  state_nxt = IDLE;
        endcase
    end

    // Write strobe, next pixel index and error/completion events for this beat.
    always_comb begin
        snk.ready = (state != IDLE);
        wr_en     = 1'b0;
        wr_addr   = idx;
        idx_nxt   = idx;
        set_sop   = 1'b0;
        set_len   = 1'b0;
        done      = 1'b0;
        case (state)
            WAIT_SOP: begin
                if (capture_en && hs && snk.startofpacket) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    if (SingleBeat && snk.endofpacket) begin
                        done    = 1'b1;
                        idx_nxt = '0;
                    end else begin
                        idx_nxt = AddrWidth'(1);
                    end
                end
            end
            CAPTURE: begin
                if (hs) begin
                    wr_en = 1'b1;
                    if (snk.startofpacket) begin
                        set_sop = 1'b1;
                        wr_addr = '0;
                        idx_nxt = AddrWidth'(1);
                    end else if (last || snk.endofpacket) begin
                        idx_nxt = '0;
                        if (last && snk.endofpacket) done    = 1'b1;
                        else                          set_len = 1'b1;
                    end else begin
                        idx_nxt = idx + AddrWidth'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            sop_err     <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            idx        <= idx_nxt;
            frame_done <= done;
            if (done) frame_count <= frame_count + 16'd1;
            // A new error in the same cycle as err_clear keeps the flag set.
            sop_err    <= set_sop | (sop_err & ~err_clear);
            len_err    <= set_len | (len_err & ~err_clear);
        end
    end

    frame_buffer_ram #(
        .Depth     (NumPixels),
        .Width     (NumColourBits),
        .AddrWidth (AddrWidth)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_video_frame_capture.sv
// Bench for video_frame_capture: frames driven through the stream interface,
// frame completions scoreboarded, frame buffer contents read back and compared.
module tb_video_frame_capture;
    import video_stream_pkg::*;

    localparam int NP = 144;
    localparam int CB = 12;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          capture_en, err_clear;
    logic [AW-1:0] rd_addr;
    logic [CB-1:0] rd_data;
    logic          frame_done, sop_err, len_err;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    video_frame_capture_if vif ();

    video_frame_capture #(.NumPixels(NP), .NumColourBits(CB), .AddrWidth(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .snk         (vif),
        .capture_en  (capture_en),
        .err_clear   (err_clear),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .sop_err     (sop_err),
        .len_err     (len_err)
    );

    typedef struct {
        int          idx;
        logic [7:0]  r, g, b;
        logic [11:0] q;
    } vec_t;

    vec_t        vt[5];
    int          n_chk = 0, n_pass = 0;
    int          exp_q[$];
    int          exp_count = 0;
    logic [11:0] exp_px[NP];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    function automatic logic [23:0] gen(int k, int seed);
        logic [7:0] r, g, b;
        r = 8'(k + seed * 17);
        g = 8'(k * 7 + seed);
        b = 8'(255 - k + seed * 3);
        return {r, g, b};
    endfunction

    function automatic logic [29:0] pack(logic [23:0] c);
        return {c[23:16], 2'b0, c[15:8], 2'b0, c[7:0], 2'b0};
    endfunction

    function automatic logic [11:0] quant(logic [23:0] c);
        return {c[23:20], c[15:12], c[7:4]};
    endfunction

    // Scoreboard: each expected completion carries the frame_count it should show.
    always @(negedge clk) begin
        int e;
        if (frame_done) begin
            if (exp_q.size() == 0) chk("frame_done_spurious", 32'd1, 32'd0);
            else begin
                e = exp_q.pop_front();
                chk("frame_done_count", 32'(frame_count), 32'(e));
            end
        end
    end

    task automatic beat(logic [29:0] d, bit sop, bit eop, bit gaps);
        int w = 0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            vif.valid = 1'b0;
            @(negedge clk);
        end
        vif.data = d; vif.startofpacket = sop; vif.endofpacket = eop; vif.valid = 1'b1;
        while (!vif.ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!vif.ready) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_frame(int len, int sop2, int eop_at, bit gaps, int seed,
                              bit use_tbl, int drop_at, bit expect_done);
        int          a = 0;
        logic [23:0] c;
        bit          sop, eop;
        for (int k = 0; k < len; k++) begin
            c = gen(k, seed);
            if (use_tbl)
                for (int j = 0; j < 5; j++)
                    if (vt[j].idx == k) c = {vt[j].r, vt[j].g, vt[j].b};
            if (k == drop_at) capture_en = 1'b0;
            sop = (k == 0) || (k == sop2);
            eop = (k == eop_at);
            if (sop) a = 0;
            if (eop && expect_done) begin
                exp_count++;
                exp_q.push_back(exp_count);
            end
            beat(pack(c), sop, eop, gaps);
            if (a < NP) exp_px[a] = quant(c);
            a++;
        end
        vif.valid = 1'b0; vif.startofpacket = 1'b0; vif.endofpacket = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        chk("frame_done_missing", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_frame(string nm);
        for (int a = 0; a < NP; a++) begin
            rd_addr = AW'(a);
            @(negedge clk);
            chk(nm, 32'(rd_data), 32'(exp_px[a]));
        end
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("err_clear_sop", 32'(sop_err), 32'd0);
        chk("err_clear_len", 32'(len_err), 32'd0);
    endtask

    task automatic check_flags(string nm, int cnt, bit s, bit l);
        chk({nm, "_count"}, 32'(frame_count), 32'(cnt));
        chk({nm, "_sop_err"}, 32'(sop_err), 32'(s));
        chk({nm, "_len_err"}, 32'(len_err), 32'(l));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{5,   8'hA5, 8'h3C, 8'hF0, 12'hA3F};
        vt[1] = '{0,   8'hFF, 8'h00, 8'h80, 12'hF08};
        vt[2] = '{143, 8'h12, 8'h34, 8'h56, 12'h135};
        vt[3] = '{77,  8'h00, 8'hFF, 8'h0F, 12'h0F0};
        vt[4] = '{100, 8'h8F, 8'h70, 8'h19, 12'h871};

        vif.data = '0; vif.startofpacket = 1'b0; vif.endofpacket = 1'b0; vif.valid = 1'b0;
        capture_en = 1'b1; err_clear = 1'b0; rd_addr = '0;

        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(vif.ready), 32'd0);
        chk("reset_frame_done", 32'(frame_done), 32'd0);
        check_flags("reset", 0, 1'b0, 1'b0);
        reset = 1'b1;
        #1 chk("ready_before_edge", 32'(vif.ready), 32'd0);
        @(negedge clk);
        chk("ready_after_reset", 32'(vif.ready), 32'd1);

        // Happy path with hand-picked quantisation vectors
        send_frame(NP, -1, NP - 1, 1'b0, 1, 1'b1, -1, 1'b1);
        settle();
        check_flags("happy", 1, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            rd_addr = AW'(vt[j].idx);
            @(negedge clk);
            chk("quant_vec", 32'(rd_data), 32'(vt[j].q));
        end
        check_frame("happy_px");

        // Random valid gaps
        send_frame(NP, -1, NP - 1, 1'b1, 2, 1'b0, -1, 1'b1);
        settle();
        check_flags("gaps", 2, 1'b0, 1'b0);
        check_frame("gaps_px");

        // Early EOP, then a good frame
        send_frame(100, -1, 99, 1'b0, 3, 1'b0, -1, 1'b0);
        settle();
        check_flags("early_eop", 2, 1'b0, 1'b1);
        send_frame(NP, -1, NP - 1, 1'b0, 4, 1'b0, -1, 1'b1);
        settle();
        check_flags("after_early", 3, 1'b0, 1'b1);
        check_frame("after_early_px");
        clear_errs();

        // Missing EOP on the last pixel
        send_frame(NP, -1, -1, 1'b0, 5, 1'b0, -1, 1'b0);
        settle();
        check_flags("missing_eop", 3, 1'b0, 1'b1);
        check_frame("missing_eop_px");
        clear_errs();

        // Second SOP mid-frame resynchronises
        send_frame(50 + NP, 50, 49 + NP, 1'b0, 6, 1'b0, -1, 1'b1);
        settle();
        check_flags("mid_sop", 4, 1'b1, 1'b0);
        rd_addr = '0;
        @(negedge clk);
        chk("mid_sop_addr0", 32'(rd_data), 32'(quant(gen(50, 6))));
        check_frame("mid_sop_px");
        clear_errs();

        // Pre-SOP garbage, then stop requested mid-frame
        for (int k = 0; k < 10; k++) beat(pack(gen(k, 99)), 1'b0, k == 5, 1'b0);
        send_frame(NP, -1, NP - 1, 1'b0, 7, 1'b0, 70, 1'b1);
        settle();
        chk("stop_ready_idle", 32'(vif.ready), 32'd0);
        check_flags("stop", 5, 1'b0, 1'b0);
        check_frame("stop_px");

        // Asynchronous reset in the middle of a frame
        capture_en = 1'b1;
        @(negedge clk);
        send_frame(70, -1, -1, 1'b0, 8, 1'b0, -1, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("areset_ready", 32'(vif.ready), 32'd0);
        chk("areset_frame_done", 32'(frame_done), 32'd0);
        check_flags("areset", 0, 1'b0, 1'b0);
        exp_q.delete();
        exp_count = 0;
        @(negedge clk);
        reset = 1'b1;
        send_frame(NP, -1, NP - 1, 1'b1, 9, 1'b0, -1, 1'b1);
        settle();
        check_flags("recover", 1, 1'b0, 1'b0);
        check_frame("recover_px");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/video_frame_capture.md
Name: video_frame_capture

Overview:
- Avalon-ST video sink. Accepts 30-bit RGB pixel packets (SOP/EOP-framed, valid/ready) from an upstream video source.
- Quantises each pixel to NumColourBits and writes one full frame into an on-chip frame-buffer BRAM.
- Checks packet framing against NumPixels and exposes a registered read port so a display or processing stage can fetch captured pixels.

Parameters:
- NumPixels, 12*12, pixels per frame (packet length in beats).
- NumColourBits, 12, stored bits per pixel; must be divisible by 3 (C = NumColourBits/3 bits per channel, 1 ≤ C ≤ 8).
- AddrWidth, 19, frame-buffer address width; 2^AddrWidth ≥ NumPixels.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- data  in  30  pixel, {R[7:0],2'b0,G[7:0],2'b0,B[7:0],2'b0}.
- startofpacket  in  1  first pixel of frame.
- endofpacket  in  1  last pixel of frame.
- valid  in  1  source data valid.
- ready  out  1  sink can accept a beat.
- capture_en  in  1  1 = capture frames; 0 = stop at the next frame boundary.
- err_clear  in  1  clears sticky error flags.
- rd_addr  in  AddrWidth  frame-buffer read address.
- rd_data  out  NumColourBits  pixel at rd_addr, 1-cycle latency.
- frame_done  out  1  1-cycle pulse per correctly framed frame.
- frame_count  out  16  number of completed frames, wraps at 2^16.
- sop_err  out  1  sticky; SOP received mid-frame.
- len_err  out  1  sticky; EOP early or missing.

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-low.
- Reset (reset=0): state=IDLE, ready=0, frame_done=0, frame_count=0, sop_err=0, len_err=0, pixel index idx=0. rd_data is undefined until the first read. BRAM contents are not cleared.
- Handshake: a beat transfers when valid & ready on a rising edge. ready is a registered output, driven only by state: 1 in WAIT_SOP and CAPTURE, 0 in IDLE.
- Quantise: stored = {data[29 -: C], data[19 -: C], data[9 -: C]}.
- States:
  - IDLE: if capture_en=1, go to WAIT_SOP.
  - WAIT_SOP:
    - If capture_en=0, go to IDLE.
    - A beat with SOP=1 writes address 0 and sets idx=1, then goes to CAPTURE. If EOP=1 on the same beat and NumPixels=1, treat it as frame end instead.
    - Beats without SOP are accepted and discarded, with no error.
  - CAPTURE, per beat, in priority order:
    - SOP=1: set sop_err; write address 0; idx=1; stay in CAPTURE (resync).
    - idx==NumPixels-1 and EOP=1: write; pulse frame_done next cycle; increment frame_count; idx=0; go to WAIT_SOP.
    - idx==NumPixels-1 and EOP=0: write; set len_err; idx=0; go to WAIT_SOP (frame not counted).
    - EOP=1 and idx<NumPixels-1: write; set len_err; idx=0; go to WAIT_SOP.
    - Otherwise: write at idx; idx++.
  - capture_en is ignored in CAPTURE: a frame in progress always completes or errors out.
- Write: same cycle as the handshake, to address idx (0 for an SOP beat).
- Read port: rd_data is registered from rd_addr, with 1-cycle latency. A read and a write to the same address in the same cycle returns the old data. rd_addr ≥ NumPixels returns undefined data.
- Errors: sop_err and len_err are sticky until err_clear=1. If err_clear and a new error occur in the same cycle, the set wins.
- frame_done: asserted for exactly one cycle, the cycle after the final beat's handshake.
- Asynchronous reset mid-frame: returns to IDLE immediately; the partial frame is abandoned and no error is flagged.

Decomposition:
- Package video_stream_pkg:
  - PixelWidth=30.
  - Channel MSB positions: R=29, G=19, B=9.
  - Default frame geometry constants.
  - capture_state_t enum {IDLE, WAIT_SOP, CAPTURE}.
  - This package is shared with the video source blocks.
- Sub-module frame_buffer_ram: simple dual-port BRAM (1 write port, 1 registered read port), parameterised by depth and width, coded for Quartus BRAM inference.

Test Plan (NumPixels=144, NumColourBits=12):
- Happy path: reset low 3 cycles then high; capture_en=1; send 144 beats with data=i-dependent RGB, SOP on beat 0 and EOP on beat 143, valid always high → ready=1 from cycle 2 after reset release. frame_done pulses once, the cycle after beat 143. frame_count=1. Reading addr 5 returns the quantised value: for R=0xA5, G=0x3C, B=0xF0 that is 12'hA3F.
- Backpressure/gaps: valid toggles randomly over 144 beats → only handshaken beats are written. The full frame is still captured and frame_count=1.
- Early EOP: EOP on beat 99 → len_err=1, no frame_done, frame_count unchanged. The next well-formed frame completes and gives frame_count+1.
- Mid-frame SOP: SOP again at beat 50, then 144 beats to EOP → sop_err=1, frame_done once, addr 0 holds the second SOP pixel. err_clear=1 then clears sop_err=0.
- Pre-SOP garbage and stop: 10 beats without SOP then a valid frame → garbage discarded, no errors, frame_count=1. Dropping capture_en mid-frame still completes the frame, then ready=0 in IDLE.
- Async reset mid-frame: drop reset at beat 70 → ready=0 immediately, all counters and flags 0. Recovery frame captured correctly.
